spi_act_out_rx_sched: RTL and testbench
=======================================

# spi_act_out_rx_sched

Sequencer for the activation-output readback phase. On a start pulse it frames an SPI read burst: asserts chip-select, sends a read command byte, then issues one dummy byte per requested data word. It drives `act_out_rx_stage` so the downstream SPI RX control path writes only data bytes into the RX FIFO, and it throttles dummy issue on FIFO fill level. It sits between the host-side command logic and the SPI master / RX control / FIFO datapath.

## Interface
- `DATA_WIDTH`, 8: SPI byte width; matches RX FIFO width.
- `CNT_WIDTH`, 16: width of word counters.
- `CMD_READ`, 8'h0B: command byte sent first in every burst.
- `DUMMY_BYTE`, 8'h00: byte transmitted to clock out each data word.
- `CS_SETUP`, 2: idle cycles between `spi_cs_n` falling and command issue; also the hold after the last byte.

- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; ignored while `busy`.
- `word_count` in CNT_WIDTH: data bytes to read; sampled when `start` is accepted.
- `busy` out 1: high from accepted `start` until `done`.
- `done` out 1: one-cycle pulse at burst end.
- `spi_tx_ready` in 1: SPI master idle, may accept a byte.
- `spi_tx_valid` out 1: one-cycle byte request; asserted only while `spi_tx_ready`=1.
- `spi_tx_data` out DATA_WIDTH: byte to transmit; valid with `spi_tx_valid`.
- `spi_rx_data_valid` in 1: SPI master byte-complete pulse.
- `spi_cs_n` out 1: slave select, active low.
- `fifo_almost_full` in 1: RX FIFO cannot accept two more bytes.
- `fifo_full` in 1: RX FIFO full.
- `act_out_rx_stage` out 1: enables FIFO writes of received bytes.
- `rx_count` out CNT_WIDTH: data bytes received in the current or last burst.
- `overflow` out 1: sticky; a data byte arrived while `fifo_full`=1. Cleared only by the next accepted `start`.

## Operation
- States:
  - IDLE
  - SETUP: count CS_SETUP cycles.
  - CMD: issue CMD_READ.
  - CMD_WAIT: wait for its `spi_rx_data_valid`.
  - DATA: issue DUMMY_BYTE.
  - DATA_WAIT: wait for `spi_rx_data_valid`.
  - HOLD: count CS_SETUP cycles.
  - DONE: pulse `done`, then IDLE.
- Transitions:
  - IDLE→SETUP on `start`; latch `word_count`; clear `rx_count` and `overflow`; drive `spi_cs_n`=0.
  - SETUP→CMD when the counter expires.
  - CMD→CMD_WAIT on the cycle `spi_tx_valid` is issued (`spi_tx_ready`=1).
  - CMD_WAIT→DATA on `spi_rx_data_valid` if the latched count is nonzero; otherwise →HOLD. The command-phase received byte is never written to the FIFO.
  - DATA issues a dummy only when `spi_tx_ready`=1 and `fifo_almost_full`=0; otherwise it waits indefinitely.
  - DATA→DATA_WAIT on issue.
  - DATA_WAIT on `spi_rx_data_valid`: `rx_count`+1; if `rx_count`+1 equals the latched count →HOLD, else →DATA.
  - HOLD→DONE when the counter expires, with `spi_cs_n`=1 on entry to DONE.
- `act_out_rx_stage`=1 exactly in DATA and DATA_WAIT. Each data byte's `spi_rx_data_valid` therefore falls inside the stage window.
- `overflow` sets if `spi_rx_data_valid` & `act_out_rx_stage` & `fifo_full`. The burst still completes.
- `spi_rx_data_valid` outside CMD_WAIT/DATA_WAIT is ignored.
- `start` while `busy` is dropped; there is no queuing.
- `word_count`=0: command only, no data phase, `rx_count` stays 0.
- Counters are unsigned. `word_count` up to 2^CNT_WIDTH−1 is legal with no wrap.

## Timing
- Reset values: `busy`=0, `done`=0, `spi_tx_valid`=0, `spi_tx_data`=0, `spi_cs_n`=1, `act_out_rx_stage`=0, `rx_count`=0, `overflow`=0, state IDLE.
- Reset mid-burst aborts immediately: `spi_cs_n`=1 and the stage drops asynchronously. No `done` is produced.
- All outputs are registered.
- `start` at cycle t gives `busy`=1 and `spi_cs_n`=0 at t+1.
- First `spi_tx_valid` is at t+1+CS_SETUP at the earliest.
- `spi_tx_valid` is asserted for exactly one cycle per byte and at most one byte is in flight.
- `done` asserts CS_SETUP+1 cycles after the last `spi_rx_data_valid`. `busy` falls the cycle after `done`.

## Structure
- Shared package `spi_ctrl_pkg`: state enum, CMD_READ and DUMMY_BYTE defaults, CS_SETUP default.
- One sub-module: `cycle_timer` (load/expire down-counter), reused for SETUP and HOLD.

## Test plan
- `word_count`=4, FIFO never full, SPI model with ready 8 cycles after issue: 5 tx bytes (0x0B, then 4×0x00). `rx_count`=4. `act_out_rx_stage` covers exactly the 4 data valids. `done` pulses once. `spi_cs_n` is low throughout.
- `word_count`=0: only 0x0B is sent, `act_out_rx_stage` never rises, `done` follows, `rx_count`=0.
- `word_count`=6 with `fifo_almost_full` held high after byte 2 for 20 cycles: no `spi_tx_valid` during the hold. Issue resumes on release and the total is 6 data bytes.
- `fifo_full` forced during the 3rd data valid: `overflow`=1 sticky, burst completes, next `start` clears it.
- `start` pulsed mid-burst: ignored. Counts and byte sequence are unchanged.
- `rst_n` asserted during DATA_WAIT: all outputs take reset values, including `spi_cs_n`=1. A fresh `start` with `word_count`=2 then completes normally.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI activation-readback sequencer: state encoding,
// default command/dummy bytes and chip-select timing.
package spi_ctrl_pkg;

    typedef logic [2:0] state_t;

    localparam state_t StIdle     = 3'd0;
    localparam state_t StSetup    = 3'd1;
    localparam state_t StCmd      = 3'd2;
    localparam state_t StCmdWait  = 3'd3;
    localparam state_t StData     = 3'd4;
    localparam state_t StDataWait = 3'd5;
    localparam state_t StHold     = 3'd6;
    localparam state_t StDone     = 3'd7;

    localparam logic [7:0]  CmdReadDefault   = 8'h0B;
    localparam logic [7:0]  DummyByteDefault = 8'h00;
    localparam int unsigned CsSetupDefault   = 2;

    // Chip-select is held low from SETUP through HOLD; it is already high in DONE.
    function automatic logic cs_active(input state_t s);
        return (s != StIdle) && (s != StDone);
    endfunction

    function automatic logic rx_stage(input state_t s);
        return (s == StData) || (s == StDataWait);
    endfunction

endpackage

// File: rtl/spi_act_out_rx_sched_if.sv
// Host, SPI master and RX FIFO signals seen by the readback sequencer.
interface spi_act_out_rx_sched_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  word_count;
    logic                  busy;
    logic                  done;
    logic                  spi_tx_ready;
    logic                  spi_tx_valid;
    logic [DATA_WIDTH-1:0] spi_tx_data;
    logic                  spi_rx_data_valid;
    logic                  spi_cs_n;
    logic                  fifo_almost_full;
    logic                  fifo_full;
    logic                  act_out_rx_stage;
    logic [CNT_WIDTH-1:0]  rx_count;
    logic                  overflow;

    modport master (
        input  start, word_count, spi_tx_ready, spi_rx_data_valid, fifo_almost_full, fifo_full,
        output busy, done, spi_tx_valid, spi_tx_data, spi_cs_n, act_out_rx_stage, rx_count,
        overflow
    );

    modport slave (
        output start, word_count, spi_tx_ready, spi_rx_data_valid, fifo_almost_full, fifo_full,
        input  busy, done, spi_tx_valid, spi_tx_data, spi_cs_n, act_out_rx_stage, rx_count,
        overflow
    );

endinterface

// File: rtl/cycle_timer.sv
// Load/expire down-counter used to time chip-select setup and hold.
module cycle_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             expire_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A load of N expires in the Nth cycle after loading; a load of 0 behaves like 1.
    assign expire_o = (cnt_q <= Width'(1));

endmodule

// File: rtl/spi_act_out_rx_sched.sv
// Frames an SPI read burst (command byte, then one dummy per data word) and opens the
// RX FIFO write stage only for the data bytes, throttling dummies on FIFO fill level.
module spi_act_out_rx_sched
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 8,
    parameter int unsigned          CNT_WIDTH  = 16,
    parameter logic [DATA_WIDTH-1:0] CMD_READ   = DATA_WIDTH'(CmdReadDefault),
    parameter logic [DATA_WIDTH-1:0] DUMMY_BYTE = DATA_WIDTH'(DummyByteDefault),
    parameter int unsigned          CS_SETUP   = CsSetupDefault
) (
    input logic                    clk,
    input logic                    rst_n,
    spi_act_out_rx_sched_if.master bus
);

    localparam int unsigned TimerWidth = 8;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  wc_q, wc_d;
    logic [CNT_WIDTH-1:0]  rx_count_q, rx_count_d;
    logic [CNT_WIDTH-1:0]  rx_count_inc;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  busy_q, done_q, cs_n_q, stage_q;
    logic                  timer_load, timer_expire;

    cycle_timer #(
        .Width(TimerWidth)
    ) u_cycle_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (timer_load),
        .value_i (TimerWidth'(CS_SETUP)),
        .expire_o(timer_expire)
    );

    assign rx_count_inc = rx_count_q + CNT_WIDTH'(1);

    always_comb begin
        state_d    = state_q;
        wc_d       = wc_q;
        rx_count_d = rx_count_q;
        tx_valid_d = 1'b0;
        tx_data_d  = tx_data_q;
        overflow_d = overflow_q;
        timer_load = 1'b0;

        if (bus.spi_rx_data_valid && stage_q && bus.fifo_full) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StSetup;
                    wc_d       = bus.word_count;
                    rx_count_d = '0;
                    overflow_d = 1'b0;
                    timer_load = 1'b1;
                end
            end
            StSetup: begin
                if (timer_expire) begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (bus.spi_tx_ready) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = CMD_READ;
                    state_d    = StCmdWait;
                end
            end
            StCmdWait: begin
                // The command-phase byte completes outside the stage window.
                if (bus.spi_rx_data_valid) begin
                    if (wc_q != '0) begin
                        state_d = StData;
                    end else begin
                        state_d    = StHold;
                        timer_load = 1'b1;
                    end
                end
            end
            StData: begin
                if (bus.spi_tx_ready && !bus.fifo_almost_full) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = DUMMY_BYTE;
                    state_d    = StDataWait;
                end
            end
            StDataWait: begin
                if (bus.spi_rx_data_valid) begin
                    rx_count_d = rx_count_inc;
                    if (rx_count_inc == wc_q) begin
                        state_d    = StHold;
                        timer_load = 1'b1;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StHold: begin
                if (timer_expire) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wc_q       <= '0;
            rx_count_q <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            stage_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wc_q       <= wc_d;
            rx_count_q <= rx_count_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            cs_n_q     <= !cs_active(state_d);
            stage_q    <= rx_stage(state_d);
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.spi_tx_valid     = tx_valid_q;
    assign bus.spi_tx_data      = tx_data_q;
    assign bus.spi_cs_n         = cs_n_q;
    assign bus.act_out_rx_stage = stage_q;
    assign bus.rx_count         = rx_count_q;
    assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_spi_act_out_rx_sched.sv
// Self-checking bench: table of bursts plus reset-abort sequence, with an SPI/FIFO model
// and a scoreboard of expected transmitted bytes.
module tb_spi_act_out_rx_sched;

    localparam int unsigned CsSetup = 2;
    localparam int          RxLat   = 8;
    localparam int          Period  = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_act_out_rx_sched_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();

    spi_act_out_rx_sched #(
        .DATA_WIDTH(8),
        .CNT_WIDTH (16),
        .CMD_READ  (8'h0B),
        .DUMMY_BYTE(8'h00),
        .CS_SETUP  (CsSetup)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int wc;
        int stall_after;
        int full_on;
        bit mid_start;
        int exp_rx;
        bit exp_ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    int  cfg_stall_after, cfg_full_on;
    int  tx_bad, tx_seen, data_rx, cmd_rx, stage_bad, stall_tx, done_cnt, stage_cycles;
    time first_tx_t, last_rx_t, done_t;
    int  lat, byte_idx, stall_left;
    bit  cur_is_data, prev_tx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        tx_bad = 0; tx_seen = 0; data_rx = 0; cmd_rx = 0; stage_bad = 0;
        stall_tx = 0; done_cnt = 0; stage_cycles = 0;
        first_tx_t = 0; last_rx_t = 0; done_t = 0;
    endtask

    // SPI master + FIFO model: observe DUT outputs first, then update driven inputs.
    initial begin
        bus.spi_tx_ready = 1'b1; bus.spi_rx_data_valid = 1'b0;
        bus.fifo_almost_full = 1'b0; bus.fifo_full = 1'b0;
        lat = 0; byte_idx = 0; stall_left = 0; cur_is_data = 1'b0; prev_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.spi_tx_ready = 1'b1; bus.spi_rx_data_valid = 1'b0;
                bus.fifo_almost_full = 1'b0; bus.fifo_full = 1'b0;
                lat = 0; byte_idx = 0; stall_left = 0; prev_tx = 1'b0;
            end else begin
                if (bus.spi_tx_valid) begin
                    if (!bus.spi_tx_ready || prev_tx || bus.spi_cs_n) tx_bad++;
                    if (bus.fifo_almost_full) stall_tx++;
                    if (tx_seen == 0) first_tx_t = $time;
                    tx_seen++;
                    if (exp_q.size() == 0) chk("tx_unexpected_byte", 64'd1, 64'd0);
                    else chk("tx_byte", 64'(bus.spi_tx_data), 64'(exp_q.pop_front()));
                    cur_is_data = (byte_idx != 0);
                    byte_idx++;
                end
                prev_tx = bus.spi_tx_valid;
                if (bus.act_out_rx_stage) stage_cycles++;
                if (bus.done) begin
                    if (done_cnt == 0) done_t = $time;
                    done_cnt++;
                end
                if (bus.spi_cs_n) byte_idx = 0;

                bus.spi_rx_data_valid = 1'b0;
                bus.fifo_full = 1'b0;
                if (stall_left != 0) begin
                    stall_left--;
                    if (stall_left == 0) bus.fifo_almost_full = 1'b0;
                end
                if (lat != 0) begin
                    lat--;
                    if (lat == 0) begin
                        bus.spi_rx_data_valid = 1'b1;
                        bus.spi_tx_ready = 1'b1;
                        last_rx_t = $time;
                        if (cur_is_data) begin
                            data_rx++;
                            if (!bus.act_out_rx_stage) stage_bad++;
                            if (data_rx == cfg_full_on) bus.fifo_full = 1'b1;
                            if (data_rx == cfg_stall_after) begin
                                bus.fifo_almost_full = 1'b1;
                                stall_left = 20;
                            end
                        end else begin
                            cmd_rx++;
                            if (bus.act_out_rx_stage) stage_bad++;
                        end
                    end
                end else if (bus.spi_tx_valid) begin
                    bus.spi_tx_ready = 1'b0;
                    lat = RxLat;
                end
            end
        end
    end

    task automatic run_burst(input vec_t v, input string tag);
        time start_t;
        bit  seen;
        @(negedge clk); #1;
        clear_stats();
        cfg_stall_after = v.stall_after;
        cfg_full_on     = v.full_on;
        exp_q.push_back(8'h0B);
        for (int k = 0; k < v.wc; k++) exp_q.push_back(8'h00);
        bus.start = 1'b1;
        bus.word_count = 16'(v.wc);
        start_t = $time;
        @(negedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_busy_after_start"}, 64'(bus.busy), 64'd1);
        chk({tag, "_cs_low_after_start"}, 64'(bus.spi_cs_n), 64'd0);
        chk({tag, "_overflow_cleared"}, 64'(bus.overflow), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (v.mid_start && i == 30) begin
                bus.start = 1'b1;
                bus.word_count = 16'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                seen = 1'b1;
                chk({tag, "_cs_high_in_done"}, 64'(bus.spi_cs_n), 64'd1);
                break;
            end
        end
        bus.start = 1'b0;
        if (!seen) chk({tag, "_done_timeout"}, 64'd0, 64'd1);
        @(negedge clk); #1;
        chk({tag, "_busy_after_done"}, 64'(bus.busy), 64'd0);
        @(negedge clk); #1;
        chk({tag, "_rx_count"}, 64'(bus.rx_count), 64'(v.exp_rx));
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(v.exp_ovf));
        chk({tag, "_tx_total"}, 64'(tx_seen), 64'(v.wc + 1));
        chk({tag, "_data_rx"}, 64'(data_rx), 64'(v.wc));
        chk({tag, "_cmd_rx"}, 64'(cmd_rx), 64'd1);
        chk({tag, "_stage_window"}, 64'(stage_bad), 64'd0);
        chk({tag, "_tx_protocol"}, 64'(tx_bad), 64'd0);
        chk({tag, "_tx_during_stall"}, 64'(stall_tx), 64'd0);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_scoreboard_left"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_first_tx_latency"},
            64'((first_tx_t - start_t) >= time'((CsSetup + 1) * Period - 1)), 64'd1);
        chk({tag, "_done_after_last_rx"}, 64'(done_t - last_rx_t), 64'((CsSetup + 1) * Period));
        if (v.wc == 0) chk({tag, "_stage_never_high"}, 64'(stage_cycles), 64'd0);
        exp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{wc: 4, stall_after: 0, full_on: 0, mid_start: 0, exp_rx: 4, exp_ovf: 0};
        vecs[1] = '{wc: 0, stall_after: 0, full_on: 0, mid_start: 0, exp_rx: 0, exp_ovf: 0};
        vecs[2] = '{wc: 6, stall_after: 2, full_on: 0, mid_start: 0, exp_rx: 6, exp_ovf: 0};
        vecs[3] = '{wc: 5, stall_after: 0, full_on: 3, mid_start: 0, exp_rx: 5, exp_ovf: 1};
        vecs[4] = '{wc: 3, stall_after: 0, full_on: 0, mid_start: 1, exp_rx: 3, exp_ovf: 0};
        vecs[5] = '{wc: 1, stall_after: 0, full_on: 0, mid_start: 0, exp_rx: 1, exp_ovf: 0};
        cfg_stall_after = 0;
        cfg_full_on = 0;
        clear_stats();
        bus.start = 1'b0;
        bus.word_count = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        chk("reset_tx_valid", 64'(bus.spi_tx_valid), 64'd0);
        chk("reset_tx_data", 64'(bus.spi_tx_data), 64'd0);
        chk("reset_cs_n", 64'(bus.spi_cs_n), 64'd1);
        chk("reset_stage", 64'(bus.act_out_rx_stage), 64'd0);
        chk("reset_rx_count", 64'(bus.rx_count), 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);
        #2 rst_n = 1'b1;

        for (int n = 0; n < 6; n++) begin
            run_burst(vecs[n], $sformatf("vec%0d", n));
        end

        // Abort a burst with reset while the second data byte is in flight.
        @(negedge clk); #1;
        clear_stats();
        cfg_stall_after = 0;
        cfg_full_on = 0;
        exp_q.push_back(8'h0B);
        for (int k = 0; k < 5; k++) exp_q.push_back(8'h00);
        bus.start = 1'b1;
        bus.word_count = 16'd5;
        @(negedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 500 && tx_seen < 3; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        #1;
        chk("abort_reached_data_wait", 64'(tx_seen), 64'd3);
        chk("abort_stage_before_reset", 64'(bus.act_out_rx_stage), 64'd1);
        chk("abort_rx_count_before_reset", 64'(bus.rx_count), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", 64'(bus.spi_cs_n), 64'd1);
        chk("abort_stage", 64'(bus.act_out_rx_stage), 64'd0);
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_tx_valid", 64'(bus.spi_tx_valid), 64'd0);
        chk("abort_rx_count", 64'(bus.rx_count), 64'd0);
        chk("abort_overflow", 64'(bus.overflow), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("abort_no_done", 64'(done_cnt), 64'd0);
        run_burst('{wc: 2, stall_after: 0, full_on: 0, mid_start: 0, exp_rx: 2, exp_ovf: 0},
                  "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
